debug_frame_sender: RTL
=======================

# debug_frame_sender

Sequences the UART transmitter so it dumps one snapshot of pipeline debug state per request. Latches the concatenated ID/EX, EX/MEM, MEM/WB, WB/ID and control words into a shadow register. Serializes them as a framed byte stream: header, payload MSB-first, optional checksum. Sits between the pipeline debug taps, the UART interface command logic (requester) and the uart_tx byte handshake.

## Interface
Parameters:
- NB_DATA, 8, UART byte width.
- NB_ID_EX, 144, ID/EX snapshot width; multiple of NB_DATA.
- NB_EX_MEM, 32, EX/MEM snapshot width; multiple of NB_DATA.
- NB_MEM_WB, 40, MEM/WB snapshot width; multiple of NB_DATA.
- NB_WB_ID, 40, WB/ID snapshot width; multiple of NB_DATA.
- NB_CONTROL, 24, control snapshot width; multiple of NB_DATA.
- HEADER, 8'hA5, first byte of every frame.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_dump_req  in  1  single-cycle request to send one frame.
- i_concatenated_data_ID_EX  in  NB_ID_EX  ID/EX debug word.
- i_concatenated_data_EX_MEM  in  NB_EX_MEM  EX/MEM debug word.
- i_concatenated_data_MEM_WB  in  NB_MEM_WB  MEM/WB debug word.
- i_concatenated_data_WB_ID  in  NB_WB_ID  WB/ID debug word.
- i_concatenated_data_CONTROL  in  NB_CONTROL  control debug word.
- i_txDone  in  1  uart_tx byte-complete pulse.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_data  out  NB_DATA  byte presented to uart_tx.
- o_busy  out  1  high from the accepted request until o_done.
- o_done  out  1  one-cycle pulse after the last byte completes.

## Operation
- Total payload P = (NB_ID_EX+NB_EX_MEM+NB_MEM_WB+NB_WB_ID+NB_CONTROL)/NB_DATA bytes. With defaults, P = 35.
- Frame length N = 1 + P, plus 1 more byte with checksum enabled. With defaults, N = 36 or 37.
- States:
  - IDLE: if i_dump_req, capture the shadow = {ID_EX, EX_MEM, MEM_WB, WB_ID, CONTROL}, byte index = 0, go to SEND. Otherwise stay.
  - SEND: o_tx_start = 1 for this cycle only; go to WAIT.
  - WAIT: on i_txDone, if index == N-1 go to DONE; else index+1 and go to SEND.
  - DONE: o_done = 1; go to IDLE.
- Byte order:
  - Index 0 = HEADER.
  - Indices 1..P = shadow bytes, MSB first. ID_EX byte 0 is bits [NB_ID_EX-1 -: 8] of ID_EX.
  - Index N-1 = checksum, when enabled.
- Shadow is loaded only in IDLE on an accepted request. Input changes during a frame do not affect sent bytes.
- i_dump_req outside IDLE is ignored and not queued.
- i_txDone outside WAIT is ignored.
- i_dump_req in the DONE cycle is ignored. A request is accepted from the following IDLE cycle.
- o_data is registered. It is stable from the SEND cycle until the i_txDone that ends that byte.
- Index counter width: clog2(N). It never wraps: the frame ends at N-1.

## Timing
- Reset values: state IDLE, o_tx_start 0, o_data 8'h00, o_busy 0, o_done 0, index 0, shadow 0.
- i_dump_req sampled high at cycle k gives:
  - o_busy = 1 from k+1;
  - o_tx_start = 1 and o_data = HEADER at k+1.
- i_txDone at cycle m (in WAIT) gives o_tx_start for the next byte at m+1.
- i_txDone for the last byte at cycle m gives o_done = 1 at m+1, with o_busy = 1 at m+1 and 0 at m+2.
- Back-to-back: the earliest new request is accepted at m+2 (first IDLE cycle).
- i_rst mid-frame: state returns to IDLE next cycle with all outputs at reset values. The partial frame is abandoned and o_done is not pulsed.
- i_rst and i_dump_req in the same cycle: reset wins and the request is dropped.

## Configuration
- DEBUG_FRAME_CHECKSUM_EN defined: one trailing byte is appended, N = P+2. It is the XOR of all preceding frame bytes, including HEADER, accumulated in a register cleared on request acceptance.
- Not defined: no checksum byte, N = P+1, and no accumulator logic is synthesized.

## Test plan
- Reset: hold i_rst 3 cycles with i_dump_req = 1 -> o_tx_start, o_busy and o_done stay 0 and o_data = 8'h00 throughout.
- Full frame with defaults, ID_EX = 144'h0102..., other words incrementing, bench model answering each o_tx_start with i_txDone after 5 cycles -> 36 bytes (37 with checksum), in order A5, 01, 02, ..., then CONTROL LSB byte. With checksum, the last byte equals the XOR of the prior 36 bytes. Exactly one o_done pulse follows.
- Snapshot isolation: change all inputs to all-ones right after acceptance -> transmitted payload equals the values captured at the request cycle.
- Request while busy: pulse i_dump_req at byte 10 and in the DONE cycle -> both ignored, only one frame sent. A request at the first IDLE cycle starts a new frame with A5.
- Spurious i_txDone in IDLE and during SEND -> byte index does not advance and no byte is skipped.
- Reset at byte 20 -> next cycle o_busy = 0, no o_done. A following request restarts with HEADER 8'hA5.

Source files
------------

// File: rtl/debug_frame_sender.sv
// debug_frame_sender
// Dumps one snapshot of pipeline debug state per request through the uart_tx
// byte handshake: HEADER, then ID/EX, EX/MEM, MEM/WB, WB/ID, CONTROL bytes MSB
// first, then an optional XOR checksum byte.
// Build option: define DEBUG_FRAME_CHECKSUM_EN to append the checksum byte.
//
// state | meaning
// IDLE  | waiting for i_dump_req; snapshot captured on acceptance
// SEND  | one-cycle o_tx_start for the byte held in r_data
// WAIT  | waiting for i_txDone of the current byte
// DONE  | one-cycle o_done pulse, request ignored here

module debug_frame_sender #(
    parameter int          NB_DATA    = 8,
    parameter int          NB_ID_EX   = 144,
    parameter int          NB_EX_MEM  = 32,
    parameter int          NB_MEM_WB  = 40,
    parameter int          NB_WB_ID   = 40,
    parameter int          NB_CONTROL = 24,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_dump_req,
    input  logic [NB_ID_EX-1:0]   i_concatenated_data_ID_EX,
    input  logic [NB_EX_MEM-1:0]  i_concatenated_data_EX_MEM,
    input  logic [NB_MEM_WB-1:0]  i_concatenated_data_MEM_WB,
    input  logic [NB_WB_ID-1:0]   i_concatenated_data_WB_ID,
    input  logic [NB_CONTROL-1:0] i_concatenated_data_CONTROL,
    input  logic                  i_txDone,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NB_SHADOW = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
    localparam int P         = NB_SHADOW / NB_DATA;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam int N         = P + 2;
`else
    localparam int N         = P + 1;
`endif
    localparam int IDX_W     = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDX_W-1:0]       r_idx;
    logic [NB_SHADOW-1:0]   r_shadow;
    logic [NB_DATA-1:0]     r_data;
    logic                   w_accept;
    logic                   w_advance;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_PREV_IDX = IDX_W'(N - 2);
    logic [NB_DATA-1:0]     r_csum;
`endif

    assign w_accept  = (r_state == IDLE) && i_dump_req;
    assign w_advance = (r_state == WAIT) && i_txDone && (r_idx != LAST_IDX);
    assign o_data    = r_data;

    // State register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        o_tx_start   = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_dump_req) w_next_state = SEND;
            end
            SEND: begin
                o_tx_start   = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (i_txDone) w_next_state = (r_idx == LAST_IDX) ? DONE : SEND;
            end
            DONE: begin
                o_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Snapshot capture, byte index and byte register. The shadow shifts left
    // as bytes are consumed so the next payload byte is always at the top.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_idx    <= '0;
            r_shadow <= '0;
            r_data   <= '0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_shadow <= {i_concatenated_data_ID_EX, i_concatenated_data_EX_MEM,
                         i_concatenated_data_MEM_WB, i_concatenated_data_WB_ID,
                         i_concatenated_data_CONTROL};
            r_data   <= HEADER;
        end else if (w_advance) begin
            r_idx <= r_idx + 1'b1;
`ifdef DEBUG_FRAME_CHECKSUM_EN
            if (r_idx == CSUM_PREV_IDX) begin
                r_data <= r_csum;
            end else begin
                r_data   <= r_shadow[NB_SHADOW-1 -: NB_DATA];
                r_shadow <= r_shadow << NB_DATA;
            end
`else
            r_data   <= r_shadow[NB_SHADOW-1 -: NB_DATA];
            r_shadow <= r_shadow << NB_DATA;
`endif
        end
    end

`ifdef DEBUG_FRAME_CHECKSUM_EN
    // Running XOR of every byte launched so far, header included
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (r_state == SEND) begin
            r_csum <= r_csum ^ r_data;
        end
    end
`endif

endmodule
